prog_mem_responder: RTL and testbench
=====================================

Name: prog_mem_responder

Overview:
- Program-memory responder on the fetcher read interface.
- Serves instruction-read requests from NUM_CONSUMERS core fetchers over one external program-memory channel.
- Arbitrates round-robin and forwards one request at a time to memory.
- Returns the fetched word to the requesting fetcher with a ready handshake; sits between the per-core fetchers and the program memory port.

Parameters:
- NUM_CONSUMERS, 4, number of fetchers served (>=1).
- ADDR_BITS, 8, program memory address width.
- DATA_BITS, 16, instruction word width.
- TIMEOUT_CYCLES, 64, memory wait limit (used only with PROG_MEM_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- consumer_read_valid  input  NUM_CONSUMERS  per-fetcher request, held high until ready seen.
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  per-fetcher address; slice i = [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  output  NUM_CONSUMERS  per-fetcher response-valid.
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  per-fetcher returned word.
- mem_read_valid  output  1  request to program memory.
- mem_read_address  output  ADDR_BITS  memory address.
- mem_read_ready  input  1  memory response valid; mem_read_data valid in the same cycle.
- mem_read_data  input  DATA_BITS  memory word.
- timeout_error  output  1  sticky timeout flag; constant 0 without the macro.

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; round-robin pointer = NUM_CONSUMERS-1, so consumer 0 has first priority.
- All other updates are on the rising clk edge.
- FSM states: IDLE, READ_WAITING, RELAYING.
- IDLE:
  - Scan consumer_read_valid starting at pointer+1, wrapping mod NUM_CONSUMERS.
  - First set bit i is granted: grant<=i, pointer<=i, mem_read_valid<=1, mem_read_address<=address slice i, go to READ_WAITING.
  - No requests: stay IDLE.
- READ_WAITING:
  - mem_read_valid and mem_read_address are held stable.
  - On mem_read_ready=1: consumer_read_data slice grant<=mem_read_data, consumer_read_ready[grant]<=1, mem_read_valid<=0, go to RELAYING.
- RELAYING:
  - consumer_read_ready[grant] stays 1 while consumer_read_valid[grant]=1.
  - When consumer_read_valid[grant]=0: consumer_read_ready[grant]<=0, go to IDLE.
- Latency: request sampled at edge N gives mem_read_valid=1 after edge N. Memory response at edge M gives consumer_read_ready=1 after edge M. At least one IDLE cycle separates transactions.
- Only one consumer_read_ready bit is ever high. consumer_read_data slices hold their last value until overwritten by a response to that consumer.
- Requests from non-granted consumers are ignored until re-arbitration; their valid stays pending.
- Protocol violation, granted consumer drops valid during READ_WAITING: the memory transaction still completes and data is stored. Ready is asserted for exactly one cycle, since valid is already low in RELAYING.
- Simultaneous requests: strict round-robin. After serving i, the next grant goes to the nearest requester above i, wrapping.
- NUM_CONSUMERS=1: the pointer is constant 0 and behaviour is otherwise identical.
- Reset mid-transaction: the in-flight memory request is abandoned (mem_read_valid drops asynchronously). The memory side must tolerate this.

Optional Feature:
- Macro: PROG_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to READ_WAITING and increments each cycle in READ_WAITING.
  - If it reaches TIMEOUT_CYCLES without mem_read_ready: mem_read_valid<=0, the granted consumer_read_data slice <= 0 (NOP), consumer_read_ready[grant]<=1, timeout_error<=1 (sticky until reset), go to RELAYING.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; READ_WAITING waits indefinitely; timeout_error tied 0.

Test Plan:
- Reset, then consumer 0 requests address 0x12; memory answers 0xA5C3 after 3 cycles -> mem_read_address=0x12; consumer_read_ready[0] high with data slice 0 = 0xA5C3; ready clears the edge after valid drops.
- Consumers 0–3 all request together (addresses 0x00, 0x10, 0x20, 0x30), memory answers with zero wait and each fetcher drops valid immediately -> grant order 0,1,2,3 -> each slice receives the word for its own address.
- Consumer 2 served, then consumers 1 and 3 request together -> 3 is granted before 1.
- Assert reset=0 mid READ_WAITING -> mem_read_valid, all ready bits, data and timeout_error read 0 immediately, without waiting for a clock edge. After release, a consumer 0 request is served first.
- Consumer 1 drops valid during READ_WAITING -> memory completes, consumer_read_ready[1] high exactly 1 cycle, FSM back to IDLE.
- With PROG_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never ready -> after 8 wait cycles consumer data=0x0000, ready=1, timeout_error=1 and stays 1.

Source files
------------

// File: rtl/prog_mem_responder.sv
// rtl/prog_mem_responder.sv - round-robin program-memory read responder for NUM_CONSUMERS fetchers
// Optional wait-limit watchdog enabled by defining PROG_MEM_TIMEOUT_EN.
module prog_mem_responder #(
    parameter int NUM_CONSUMERS  = 4,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               timeout_error
);

    localparam int GW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [GW-1:0] PTR_RST = GW'(NUM_CONSUMERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAITING,
        RELAYING
    } state_t;

    state_t                             state_q, state_d;
    logic [GW-1:0]                      grant_q, grant_d;
    logic [GW-1:0]                      ptr_q, ptr_d;
    logic                               mem_valid_q, mem_valid_d;
    logic [ADDR_BITS-1:0]               mem_addr_q, mem_addr_d;
    logic [NUM_CONSUMERS-1:0]           ready_q, ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;
    logic [GW-1:0]                      pick;
    logic [GW-1:0]                      scan_idx;

`ifdef PROG_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_q, wait_d;
    logic          timeout_q, timeout_d;
`endif

    // Scan downward from the farthest candidate so the nearest requester above ptr_q wins.
    always_comb begin
        pick     = ptr_q;
        scan_idx = ptr_q;
        for (int k = NUM_CONSUMERS; k >= 1; k--) begin
            scan_idx = GW'((int'(ptr_q) + k) % NUM_CONSUMERS);
            if (consumer_read_valid[scan_idx]) begin
                pick = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        ready_d     = ready_q;
        data_d      = data_q;
`ifdef PROG_MEM_TIMEOUT_EN
        wait_d      = wait_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (|consumer_read_valid) begin
                    grant_d     = pick;
                    ptr_d       = pick;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = consumer_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                    state_d     = READ_WAITING;
`ifdef PROG_MEM_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
                    ready_d          = '0;
                    ready_d[grant_q] = 1'b1;
                    mem_valid_d      = 1'b0;
                    state_d          = RELAYING;
                end
`ifdef PROG_MEM_TIMEOUT_EN
                else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Hand back an all-zero word (NOP) so the fetcher is not stalled forever.
                    data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = '0;
                    ready_d          = '0;
                    ready_d[grant_q] = 1'b1;
                    mem_valid_d      = 1'b0;
                    timeout_d        = 1'b1;
                    state_d          = RELAYING;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            RELAYING: begin
                if (!consumer_read_valid[grant_q]) begin
                    ready_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= PTR_RST;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
        end
    end

`ifdef PROG_MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_error = timeout_q;
`else
    assign timeout_error = 1'b0;
`endif

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;
    assign mem_read_valid      = mem_valid_q;
    assign mem_read_address    = mem_addr_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
// tb/tb_prog_mem_responder.sv - directed scoreboard bench for prog_mem_responder
module tb_prog_mem_responder;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    consumer_read_valid;
    logic [N*AW-1:0] consumer_read_address;
    logic [N-1:0]    consumer_read_ready;
    logic [N*DW-1:0] consumer_read_data;
    logic            mem_read_valid;
    logic [AW-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DW-1:0]   mem_read_data;
    logic            timeout_error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } exp_t;
    exp_t sb[$];

    int mem_wait   = 0;
    bit mem_enable = 1'b1;
    int wcnt       = 0;

    prog_mem_responder #(
        .NUM_CONSUMERS (N),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .consumer_read_valid  (consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready  (consumer_read_ready),
        .consumer_read_data   (consumer_read_data),
        .mem_read_valid       (mem_read_valid),
        .mem_read_address     (mem_read_address),
        .mem_read_ready       (mem_read_ready),
        .mem_read_data        (mem_read_data),
        .timeout_error        (timeout_error)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 8'h12) return 16'hA5C3;
        return {a ^ 8'h5A, a};
    endfunction

    // Program memory: answers mem_wait negedges after it first sees a request.
    always @(negedge clk) begin
        if (mem_read_valid && !mem_read_ready) begin
            if (mem_enable && wcnt >= mem_wait) begin
                mem_read_ready = 1'b1;
                mem_read_data  = mem_word(mem_read_address);
                wcnt           = 0;
            end else begin
                wcnt = wcnt + 1;
            end
        end else begin
            mem_read_ready = 1'b0;
            wcnt           = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int i, input logic [AW-1:0] a, input bit push);
        consumer_read_address[i*AW +: AW] = a;
        consumer_read_valid[i] = 1'b1;
        if (push) sb.push_back('{c: i, d: mem_word(a)});
    endtask

    task automatic check_pop(input int i);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk("grant_order", 64'(i), 64'(e.c));
            chk("resp_data", 64'(consumer_read_data[i*DW +: DW]), 64'(e.d));
        end
    endtask

    // Each fetcher drops valid on the first cycle it sees ready.
    task automatic serve(input int budget);
        int n = 0;
        while ((sb.size() != 0 || consumer_read_valid != '0 || consumer_read_ready != '0) && n < budget) begin
            @(negedge clk);
            n++;
            chk("ready_onehot", 64'($countones(consumer_read_ready) <= 1), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (consumer_read_ready[i] && consumer_read_valid[i]) begin
                    check_pop(i);
                    consumer_read_valid[i] = 1'b0;
                end
            end
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("serve_quiet", 64'(consumer_read_ready), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        consumer_read_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset                 = 1'b0;
        consumer_read_valid   = '0;
        consumer_read_address = '0;
        mem_read_ready        = 1'b0;
        mem_read_data         = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", 64'(mem_read_valid), 64'd0);
        chk("rst_ready", 64'(consumer_read_ready), 64'd0);
        chk("rst_data", 64'(consumer_read_data), 64'd0);
        chk("rst_timeout", 64'(timeout_error), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single request, memory answers after 3 cycles, fetcher holds valid one extra cycle.
        mem_wait = 3;
        req(0, 8'h12, 1'b1);
        @(negedge clk);
        chk("t1_mem_valid", 64'(mem_read_valid), 64'd1);
        chk("t1_mem_addr", 64'(mem_read_address), 64'h12);
        n = 0;
        while (!consumer_read_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1_ready", 64'(consumer_read_ready), 64'd1);
        check_pop(0);
        chk("t1_mem_valid_drop", 64'(mem_read_valid), 64'd0);
        @(negedge clk);
        chk("t1_ready_held", 64'(consumer_read_ready), 64'd1);
        consumer_read_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_ready_clear", 64'(consumer_read_ready), 64'd0);

        // All four at once from a fresh pointer: grant order 0,1,2,3.
        do_reset();
        mem_wait = 0;
        req(0, 8'h00, 1'b1);
        req(1, 8'h10, 1'b1);
        req(2, 8'h20, 1'b1);
        req(3, 8'h30, 1'b1);
        serve(100);
        chk("t2_slice0", 64'(consumer_read_data[0*DW +: DW]), 64'(mem_word(8'h00)));
        chk("t2_slice3", 64'(consumer_read_data[3*DW +: DW]), 64'(mem_word(8'h30)));

        // After consumer 2, simultaneous 1 and 3 must go to 3 first.
        mem_wait = 1;
        req(2, 8'h2C, 1'b1);
        serve(50);
        sb.push_back('{c: 3, d: mem_word(8'h3D)});
        sb.push_back('{c: 1, d: mem_word(8'h1B)});
        req(1, 8'h1B, 1'b0);
        req(3, 8'h3D, 1'b0);
        serve(100);

        // Async reset in the middle of a memory wait.
        mem_enable = 1'b0;
        req(2, 8'h99, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_inflight", 64'(mem_read_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("t4_async_mem_valid", 64'(mem_read_valid), 64'd0);
        chk("t4_async_ready", 64'(consumer_read_ready), 64'd0);
        chk("t4_async_data", 64'(consumer_read_data), 64'd0);
        chk("t4_async_timeout", 64'(timeout_error), 64'd0);
        consumer_read_valid = '0;
        mem_enable = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        req(3, 8'h31, 1'b0);
        req(0, 8'h05, 1'b0);
        sb.push_back('{c: 0, d: mem_word(8'h05)});
        sb.push_back('{c: 3, d: mem_word(8'h31)});
        serve(100);

        // Granted fetcher abandons its request while memory is still busy.
        mem_wait = 4;
        req(1, 8'h44, 1'b1);
        repeat (2) @(negedge clk);
        chk("t5_waiting", 64'(mem_read_valid), 64'd1);
        consumer_read_valid[1] = 1'b0;
        n = 0;
        while (!consumer_read_ready[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_ready", 64'(consumer_read_ready), 64'd2);
        check_pop(1);
        @(negedge clk);
        chk("t5_ready_one_cycle", 64'(consumer_read_ready), 64'd0);
        mem_wait = 0;
        req(0, 8'h07, 1'b1);
        serve(50);

`ifdef PROG_MEM_TIMEOUT_EN
        mem_enable = 1'b0;
        req(3, 8'h77, 1'b0);
        n = 0;
        while (!consumer_read_ready[3] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", 64'(n), 64'd9);
        chk("to_ready", 64'(consumer_read_ready), 64'd8);
        chk("to_data_nop", 64'(consumer_read_data[3*DW +: DW]), 64'd0);
        chk("to_flag", 64'(timeout_error), 64'd1);
        consumer_read_valid[3] = 1'b0;
        repeat (2) @(negedge clk);
        chk("to_sticky", 64'(timeout_error), 64'd1);
        chk("to_ready_clear", 64'(consumer_read_ready), 64'd0);
        mem_enable = 1'b1;
`else
        chk("no_timeout_flag", 64'(timeout_error), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
